priority_encoder_hs: RTL and testbench
======================================

// Module: priority_encoder_hs
//
// PURPOSE
// - Parametrised one-hot/priority encoder: converts an IN_WIDTH-bit request vector into a binary index.
// - Registered output with a valid/ready handshake, so it can sit between pipelined producers and consumers.
// - Flags empty and multi-hot inputs explicitly; the index is never ambiguous.
// - Successor to the fixed 16-to-4 combinational encoder; serves arbitration and interrupt-vector paths.
//
// PARAMETERS
// - IN_WIDTH      16                        request vector width, >= 2
// - OUT_WIDTH     $clog2(IN_WIDTH)          index width (derived; do not override)
// - LSB_PRIORITY  1                         1: lowest set bit wins; 0: highest set bit wins
// - ERR_CNT_W     8                         width of the multi-hot error counter
//
// PORTS
// - clk        in   1          clock, all logic on rising edge
// - reset      in   1          synchronous reset, active-high
// - in_valid   in   1          in_data is valid this cycle
// - in_ready   out  1          block accepts in_data this cycle
// - in_data    in   IN_WIDTH   request vector
// - out_valid  out  1          output register holds a result
// - out_ready  in   1          consumer accepts the result
// - out_index  out  OUT_WIDTH  encoded index of the winning bit
// - out_found  out  1          at least one request bit was set
// - out_multi  out  1          more than one request bit was set
// - err_count  out  ERR_CNT_W  saturating count of accepted multi-hot inputs
//
// BEHAVIOUR
// - Reset (clk edge with reset=1): out_valid=0, out_index=0, out_found=0, out_multi=0, err_count=0.
//   Reset overrides any handshake in the same cycle; an in-flight result is discarded.
// - in_ready = !out_valid || out_ready (combinational); in_ready is forced to 0 while reset=1.
// - Accept = in_valid && in_ready. On accept, the output register loads on the next edge. Latency is 1 cycle.
// - Hold: when out_valid=1 and out_ready=0, all out_* remain stable and in_ready=0.
// - Drain: when out_valid=1 && out_ready=1 && no accept, out_valid goes to 0 and the data outputs keep their values.
// - Simultaneous drain and accept: the register reloads and out_valid stays 1 (full throughput, 1 result/cycle).
// - Index selection: LSB_PRIORITY=1 selects the lowest set bit; LSB_PRIORITY=0 selects the highest set bit.
// - in_data==0: out_found=0, out_index=0, out_multi=0. The result is still produced and handshaked.
// - out_multi = 1 iff popcount(in_data) >= 2; out_index still follows the priority rule.
// - err_count increments by 1 on each accept with out_multi=1, saturates at all-ones, and never wraps.
// - The state is a single output register stage (EMPTY/FULL encoded by out_valid). No other FSM.
//
// CONFIGURATION
// - PRIORITY_ENCODER_ERR_CNT_EN defined:
//   err_count counter is instantiated as described above.
// - Not defined:
//   - err_count is tied to 0 and no counter flops are synthesised.
//   - out_multi is still generated.
//
// TESTING
// - Reset with out_valid=1 and out_ready=0 -> next cycle out_valid=0, err_count=0, in_ready=1.
// - IN_WIDTH=16, LSB_PRIORITY=1, in_data=16'h0001, out_ready=1
//   -> 1 cycle later: out_valid=1, out_index=0, out_found=1, out_multi=0.
// - in_data=16'h8010: LSB_PRIORITY=1 gives out_index=4; LSB_PRIORITY=0 gives out_index=15.
//   Both give out_multi=1; err_count increments by 1.
// - in_data=16'h0000 -> out_found=0, out_index=0, out_multi=0, out_valid=1.
// - Back-to-back stream 16'h0002, 16'h0004, 16'h0008 with out_ready=1
//   -> indices 1, 2, 3 on consecutive cycles, no bubbles.
//   - Drop out_ready for 3 cycles mid-stream: output holds, in_ready=0, no result is lost or duplicated.
// - ERR_CNT_W=2: 5 multi-hot accepts -> err_count=3 (saturated).
//   With PRIORITY_ENCODER_ERR_CNT_EN undefined, err_count stays 0.

Source files
------------

// File: rtl/priority_encoder_hs.sv
// rtl/priority_encoder_hs.sv - priority encoder with a registered valid/ready output stage
//
// Optional feature macro: PRIORITY_ENCODER_ERR_CNT_EN
//   defined     -> saturating multi-hot error counter drives err_count
//   not defined -> err_count tied to 0, no counter flops
module priority_encoder_hs #(
  parameter int IN_WIDTH     = 16,
  parameter int OUT_WIDTH    = $clog2(IN_WIDTH),
  parameter int LSB_PRIORITY = 1,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_index,
  output logic                 out_found,
  output logic                 out_multi,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [OUT_WIDTH-1:0] enc_index;
  logic                 enc_found;
  logic                 enc_multi;
  logic                 accept;

  // The register can take a new result when empty or when its current result leaves this cycle.
  assign in_ready = !reset && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Clearing the lowest set bit leaves something behind only if two or more bits were set.
  assign enc_multi = |(in_data & (in_data - IN_WIDTH'(1)));
  assign enc_found = |in_data;

  // Scan toward the winning end so the last hit seen is the one with priority.
  always_comb begin
    enc_index = '0;
    if (LSB_PRIORITY != 0) begin
      for (int i = IN_WIDTH - 1; i >= 0; i--) begin
        if (in_data[i]) enc_index = OUT_WIDTH'(i);
      end
    end else begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (in_data[i]) enc_index = OUT_WIDTH'(i);
      end
    end
  end

  // Single output stage: load on accept, clear valid on drain, data fields hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_index <= '0;
      out_found <= 1'b0;
      out_multi <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_index <= enc_index;
      out_found <= enc_found;
      out_multi <= enc_multi;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef PRIORITY_ENCODER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Count accepted multi-hot requests, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (accept && enc_multi && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_priority_encoder_hs.sv
// tb/tb_priority_encoder_hs.sv - directed table-driven bench for priority_encoder_hs
module tb_priority_encoder_hs;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic       l_in_ready, l_out_valid, l_out_found, l_out_multi;
  logic [3:0] l_out_index;
  logic [7:0] l_err_count;
  logic       m_in_ready, m_out_valid, m_out_found, m_out_multi;
  logic [3:0] m_out_index;
  logic [7:0] m_err_count;
  logic       s_in_ready, s_out_valid, s_out_found, s_out_multi;
  logic [3:0] s_out_index;
  logic [1:0] s_err_count;

`ifdef PRIORITY_ENCODER_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  priority_encoder_hs #(.IN_WIDTH(16), .LSB_PRIORITY(1), .ERR_CNT_W(8)) dut_lsb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(l_in_ready), .in_data(in_data),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_index(l_out_index),
    .out_found(l_out_found), .out_multi(l_out_multi), .err_count(l_err_count));

  priority_encoder_hs #(.IN_WIDTH(16), .LSB_PRIORITY(0), .ERR_CNT_W(8)) dut_msb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready), .in_data(in_data),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_index(m_out_index),
    .out_found(m_out_found), .out_multi(m_out_multi), .err_count(m_err_count));

  priority_encoder_hs #(.IN_WIDTH(16), .LSB_PRIORITY(1), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_index(s_out_index),
    .out_found(s_out_found), .out_multi(s_out_multi), .err_count(s_err_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  idx_lsb;
    logic [3:0]  idx_msb;
    logic        found;
    logic        multi;
  } vec_t;

  vec_t vecs[8];
  int   n_cmp;
  int   n_err;
  int   e8;
  int   e2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_err();
    if (e8 < 255) e8++;
    if (e2 < 3) e2++;
  endtask

  task automatic chk_err(input string tag);
    chk({tag, " lsb err_count"}, 32'(l_err_count), CNT_EN ? e8 : 0);
    chk({tag, " msb err_count"}, 32'(m_err_count), CNT_EN ? e8 : 0);
    chk({tag, " sat err_count"}, 32'(s_err_count), CNT_EN ? e2 : 0);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] il,
                         input logic [3:0] im, input logic f, input logic mu);
    chk({tag, " lsb out_valid"}, 32'(l_out_valid), 32'(v));
    chk({tag, " lsb out_index"}, 32'(l_out_index), 32'(il));
    chk({tag, " lsb out_found"}, 32'(l_out_found), 32'(f));
    chk({tag, " lsb out_multi"}, 32'(l_out_multi), 32'(mu));
    chk({tag, " msb out_valid"}, 32'(m_out_valid), 32'(v));
    chk({tag, " msb out_index"}, 32'(m_out_index), 32'(im));
    chk({tag, " msb out_found"}, 32'(m_out_found), 32'(f));
    chk({tag, " msb out_multi"}, 32'(m_out_multi), 32'(mu));
    chk({tag, " sat out_index"}, 32'(s_out_index), 32'(il));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    e8 = 0;
    e2 = 0;

    vecs[0] = '{16'h0001, 4'd0,  4'd0,  1'b1, 1'b0};
    vecs[1] = '{16'h8010, 4'd4,  4'd15, 1'b1, 1'b1};
    vecs[2] = '{16'h0000, 4'd0,  4'd0,  1'b0, 1'b0};
    vecs[3] = '{16'h8000, 4'd15, 4'd15, 1'b1, 1'b0};
    vecs[4] = '{16'hFFFF, 4'd0,  4'd15, 1'b1, 1'b1};
    vecs[5] = '{16'h0006, 4'd1,  4'd2,  1'b1, 1'b1};
    vecs[6] = '{16'h0100, 4'd8,  4'd8,  1'b1, 1'b0};
    vecs[7] = '{16'h5000, 4'd12, 4'd14, 1'b1, 1'b1};

    // reset state
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h0003;
    out_ready = 1'b0;
    step();
    step();
    chk_out("reset", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    chk_err("reset");
    chk("reset in_ready", 32'(l_in_ready), 0);

    // load a multi-hot result, stall it, then reset over it
    reset = 1'b0;
    #1;
    chk("pre in_ready", 32'(l_in_ready), 1);
    step();
    chk_out("stallload", 1'b1, 4'd0, 4'd1, 1'b1, 1'b1);
    chk("stallload in_ready", 32'(l_in_ready), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_out("rst_over", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    chk_err("rst_over");
    chk("rst_over in_ready", 32'(l_in_ready), 1);

    // table: back-to-back accepts with consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = vecs[i].data;
      #1;
      chk($sformatf("vec%0d in_ready", i), 32'(l_in_ready), 1);
      step();
      if (vecs[i].multi) bump_err();
      chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].idx_lsb, vecs[i].idx_msb,
              vecs[i].found, vecs[i].multi);
      chk_err($sformatf("vec%0d", i));
    end
    in_valid = 1'b0;
    step();
    chk_out("drain", 1'b0, 4'd12, 4'd14, 1'b1, 1'b1);

    // stream 2,4,8 with a 3-cycle consumer stall after the first result
    in_valid = 1'b1;
    in_data = 16'h0002;
    step();
    chk_out("s0", 1'b1, 4'd1, 4'd1, 1'b1, 1'b0);
    out_ready = 1'b0;
    in_data = 16'h0004;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold%0d in_ready", k), 32'(l_in_ready), 0);
      step();
      chk_out($sformatf("hold%0d", k), 1'b1, 4'd1, 4'd1, 1'b1, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("resume in_ready", 32'(l_in_ready), 1);
    step();
    chk_out("s1", 1'b1, 4'd2, 4'd2, 1'b1, 1'b0);
    in_data = 16'h0008;
    step();
    chk_out("s2", 1'b1, 4'd3, 4'd3, 1'b1, 1'b0);
    in_valid = 1'b0;
    step();
    chk_out("s_drain", 1'b0, 4'd3, 4'd3, 1'b1, 1'b0);
    chk_err("stream");

    // saturation: five multi-hot accepts from a clean counter
    reset = 1'b1;
    step();
    reset = 1'b0;
    e8 = 0;
    e2 = 0;
    chk_err("sat_rst");
    in_valid = 1'b1;
    in_data = 16'h0011;
    for (int k = 0; k < 5; k++) begin
      step();
      bump_err();
      chk_err($sformatf("sat%0d", k));
    end
    chk("sat final", 32'(s_err_count), CNT_EN ? 3 : 0);
    in_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
